// File: rtl/pe_net_if.sv
// PE-side endpoint of the ring switch's change-detect byte link.
// There is no valid strobe on the link, so any change of the 8-bit bus value
// marks a new word. TX buffers PE payloads and launches them with a rolling
// 2-bit sequence field, which keeps successive words distinct. RX captures
// every observed bus change into a FIFO for the PE.
module pe_net_if #(
    parameter int RANK     = 0,
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4,
    parameter int TX_GAP   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [1:0] tx_dst,
    input  logic [3:0] tx_data,
    output logic [7:0] net_tx,
    input  logic [7:0] net_rx,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_overflow,
    output logic       tx_busy
);

    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int HW  = (TX_GAP > 1) ? $clog2(TX_GAP) : 1;
    localparam logic [TAW:0]  TX_CNT_MAX = TX_DEPTH[TAW:0];
    localparam logic [RAW:0]  RX_CNT_MAX = RX_DEPTH[RAW:0];
    localparam logic [HW-1:0] HOLD_INIT  = HW'(TX_GAP - 1);

    // RANK only identifies this endpoint on the ring; it never filters traffic.
    // Catch out-of-range parameters at elaboration instead of misbehaving.
    if (RANK < 0 || RANK > 3 || TX_DEPTH < 2 || RX_DEPTH < 2 || TX_GAP < 1 ||
        (TX_DEPTH & (TX_DEPTH - 1)) != 0 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_param_chk
        $error("pe_net_if: parameter out of range");
    end

    typedef struct packed {
        logic [1:0] dst;
        logic [3:0] data;
    } tx_ent_t;

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    // ---------------- TX FIFO ----------------
    tx_ent_t        tx_mem [TX_DEPTH];
    logic [TAW-1:0] tx_wr, tx_rd;
    logic [TAW:0]   tx_cnt;
    logic           tx_full, tx_push, launch;
    tx_ent_t        tx_head;

    state_t         state;
    logic [HW-1:0]  hold_cnt;
    logic [1:0]     seq, seq_n;

    assign tx_full  = (tx_cnt == TX_CNT_MAX);
    assign tx_ready = !tx_full;
    assign tx_push  = tx_valid && !tx_full;
    assign tx_head  = tx_mem[tx_rd];
    // A word may launch from IDLE or on the last HOLD cycle; the latter gives
    // exactly TX_GAP cycles per word when the queue stays non-empty.
    assign launch   = (tx_cnt != '0) && (state == S_IDLE || hold_cnt == '0);
    // Sequence skips 00 so the first word after reset differs from net_tx=00h.
    assign seq_n    = (seq == 2'b11) ? 2'b01 : seq + 2'd1;
    assign tx_busy  = (tx_cnt != '0) || (state == S_HOLD);

    // TX storage write; contents are don't-care until the pointers cover them
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr] <= {tx_dst, tx_data};
    end

    // TX pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr  <= '0;
            tx_rd  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + 1'b1;
            if (launch)  tx_rd <= tx_rd + 1'b1;
            case ({tx_push, launch})
                2'b10:   tx_cnt <= tx_cnt + 1'b1;
                2'b01:   tx_cnt <= tx_cnt - 1'b1;
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    // Launcher FSM: pop, drive the registered word, then hold it TX_GAP cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
            seq      <= 2'b00;
            net_tx   <= 8'h00;
        end else if (launch) begin
            net_tx   <= {seq_n, tx_head.dst, tx_head.data};
            seq      <= seq_n;
            hold_cnt <= HOLD_INIT;
            state    <= S_HOLD;
        end else if (state == S_HOLD) begin
            if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
            else                state    <= S_IDLE;
        end
    end

    // ---------------- RX detect + FIFO ----------------
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [RAW-1:0] rx_wr, rx_rd;
    logic [RAW:0]   rx_cnt;
    logic [7:0]     rx_prev;
    logic           rx_change, rx_full, rx_pop, rx_push;

    assign rx_valid  = (rx_cnt != '0);
    assign rx_full   = (rx_cnt == RX_CNT_MAX);
    assign rx_change = (net_rx != rx_prev);
    assign rx_pop    = rx_valid && rx_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign rx_push   = rx_change && (!rx_full || rx_pop);
    assign rx_data   = rx_valid ? rx_mem[rx_rd] : 8'h00;

    // RX storage write
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr] <= net_rx;
    end

    // Change tracking, RX pointers/occupancy and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_prev     <= 8'h00;
            rx_wr       <= '0;
            rx_rd       <= '0;
            rx_cnt      <= '0;
            rx_overflow <= 1'b0;
        end else begin
            if (rx_change) rx_prev <= net_rx;
            if (rx_change && !rx_push) rx_overflow <= 1'b1;
            if (rx_push) rx_wr <= rx_wr + 1'b1;
            if (rx_pop)  rx_rd <= rx_rd + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + 1'b1;
                2'b01:   rx_cnt <= rx_cnt - 1'b1;
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_net_if.sv
// Directed bench for pe_net_if: one instance with TX_GAP=1 (also used for RX),
// one with TX_GAP=3 (fill/hold timing and mid-hold reset).
module tb_pe_net_if;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // instance a: TX_GAP=1
    logic       a_tx_valid, a_tx_ready, a_rx_valid, a_rx_ready, a_rx_overflow, a_tx_busy;
    logic [1:0] a_tx_dst;
    logic [3:0] a_tx_data;
    logic [7:0] a_net_tx, a_net_rx, a_rx_data;
    // instance b: TX_GAP=3
    logic       b_tx_valid, b_tx_ready, b_rx_valid, b_rx_ready, b_rx_overflow, b_tx_busy;
    logic [1:0] b_tx_dst;
    logic [3:0] b_tx_data;
    logic [7:0] b_net_tx, b_net_rx, b_rx_data;

    pe_net_if #(.RANK(0), .TX_DEPTH(4), .RX_DEPTH(4), .TX_GAP(1)) u_a (
        .clk(clk), .rst_n(rst_n),
        .tx_valid(a_tx_valid), .tx_ready(a_tx_ready), .tx_dst(a_tx_dst), .tx_data(a_tx_data),
        .net_tx(a_net_tx), .net_rx(a_net_rx),
        .rx_valid(a_rx_valid), .rx_ready(a_rx_ready), .rx_data(a_rx_data),
        .rx_overflow(a_rx_overflow), .tx_busy(a_tx_busy)
    );

    pe_net_if #(.RANK(1), .TX_DEPTH(4), .RX_DEPTH(4), .TX_GAP(3)) u_b (
        .clk(clk), .rst_n(rst_n),
        .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .tx_dst(b_tx_dst), .tx_data(b_tx_data),
        .net_tx(b_net_tx), .net_rx(b_net_rx),
        .rx_valid(b_rx_valid), .rx_ready(b_rx_ready), .rx_data(b_rx_data),
        .rx_overflow(b_rx_overflow), .tx_busy(b_tx_busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // advance one clock; inputs change and outputs are sampled 1 unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // TX_GAP=3 words {seq,dst=1,data=i}, seq = 01,10,11,01,10,11
    logic [7:0] b_exp [6];
    logic [7:0] rx_drain [4];

    initial begin
        b_exp    = '{8'h50, 8'h91, 8'hD2, 8'h53, 8'h94, 8'hD5};
        rx_drain = '{8'h22, 8'h33, 8'h44, 8'h66};
        a_tx_valid = 0; a_tx_dst = 0; a_tx_data = 0; a_net_rx = 8'h00; a_rx_ready = 0;
        b_tx_valid = 0; b_tx_dst = 0; b_tx_data = 0; b_net_rx = 8'h00; b_rx_ready = 0;

        // ---- reset, then idle for 10 cycles ----
        tick(); tick();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk8("idle_net_tx", a_net_tx, 8'h00);
            chk1("idle_rx_valid", a_rx_valid, 1'b0);
            chk1("idle_tx_ready", a_tx_ready, 1'b1);
            chk1("idle_rx_overflow", a_rx_overflow, 1'b0);
        end
        chk8("idle_rx_data", a_rx_data, 8'h00);
        chk1("idle_tx_busy", a_tx_busy, 1'b0);

        // ---- TX_GAP=1: three identical payloads back to back ----
        a_tx_valid = 1; a_tx_dst = 2'd2; a_tx_data = 4'd5;
        tick();                                   // push 0
        chk8("g1_latency", a_net_tx, 8'h00);
        chk1("g1_busy_queued", a_tx_busy, 1'b1);
        tick();                                   // push 1, launch 0
        chk8("g1_word0", a_net_tx, 8'h65);
        tick();                                   // push 2, launch 1
        a_tx_valid = 0;
        chk8("g1_word1", a_net_tx, 8'hA5);
        chk1("g1_ready", a_tx_ready, 1'b1);
        tick();                                   // launch 2
        chk8("g1_word2", a_net_tx, 8'hE5);
        chk1("g1_busy_lasthold", a_tx_busy, 1'b1);
        tick();
        chk8("g1_hold_last", a_net_tx, 8'hE5);
        chk1("g1_busy_fall", a_tx_busy, 1'b0);

        // ---- RX: 00 -> 3C -> 3C -> C1, then pop both ----
        a_net_rx = 8'h3C; tick();
        tick();                                   // repeat value, not a new word
        a_net_rx = 8'hC1; tick();
        chk1("rx_valid_two", a_rx_valid, 1'b1);
        chk8("rx_head_3c", a_rx_data, 8'h3C);
        a_rx_ready = 1; tick();
        chk8("rx_head_c1", a_rx_data, 8'hC1);
        chk1("rx_valid_one", a_rx_valid, 1'b1);
        tick();
        chk1("rx_valid_empty", a_rx_valid, 1'b0);
        chk8("rx_data_empty", a_rx_data, 8'h00);
        a_rx_ready = 0;

        // ---- RX overflow: 5 changes into a 4-deep FIFO ----
        a_net_rx = 8'h11; tick();
        a_net_rx = 8'h22; tick();
        a_net_rx = 8'h33; tick();
        a_net_rx = 8'h44; tick();
        chk1("ovf_not_yet", a_rx_overflow, 1'b0);
        a_net_rx = 8'h55; tick();
        chk1("ovf_set", a_rx_overflow, 1'b1);
        chk8("ovf_head", a_rx_data, 8'h11);
        tick();
        chk1("ovf_sticky", a_rx_overflow, 1'b1);
        // full FIFO: change plus same-cycle pop is accepted
        a_net_rx = 8'h66; a_rx_ready = 1; tick();
        a_rx_ready = 0;
        chk8("full_pop_head", a_rx_data, 8'h22);
        a_rx_ready = 1;
        for (int i = 0; i < 4; i++) begin
            chk8("drain", a_rx_data, rx_drain[i]);
            tick();
        end
        a_rx_ready = 0;
        chk1("drain_empty", a_rx_valid, 1'b0);
        chk1("ovf_still", a_rx_overflow, 1'b1);

        // ---- TX_GAP=3: fill with tx_valid held high, 3-cycle hold per word ----
        b_tx_dst = 2'd1;
        for (int cyc = 1; cyc <= 19; cyc++) begin
            b_tx_valid = (cyc <= 6);
            b_tx_data  = 4'(cyc - 1);
            tick();
            if (cyc >= 2) chk8("g3_word", b_net_tx, b_exp[(cyc - 2) / 3]);
            if (cyc == 5) chk1("g3_ready_before_full", b_tx_ready, 1'b1);
            if (cyc == 6) chk1("g3_ready_full", b_tx_ready, 1'b0);
        end
        chk1("g3_busy_hold", b_tx_busy, 1'b1);
        tick();
        chk1("g3_busy_fall", b_tx_busy, 1'b0);
        chk8("g3_hold_last", b_net_tx, 8'hD5);

        // ---- async reset while in HOLD with two entries queued ----
        b_tx_valid = 1; b_tx_dst = 2'd3; b_tx_data = 4'hA; tick();
        b_tx_data = 4'hB; tick();
        chk8("rst_pre_word", b_net_tx, 8'h7A);
        b_tx_data = 4'hC; tick();
        b_tx_valid = 0;
        chk1("rst_pre_busy", b_tx_busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk8("rst_net_tx", b_net_tx, 8'h00);
        chk1("rst_busy", b_tx_busy, 1'b0);
        chk1("rst_ready", b_tx_ready, 1'b1);
        chk1("rst_ovf_clr", a_rx_overflow, 1'b0);
        a_net_rx = 8'h00;
        tick();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk8("rst_no_partial", b_net_tx, 8'h00);
            chk1("rst_queue_empty", b_tx_busy, 1'b0);
        end
        b_tx_valid = 1; b_tx_dst = 2'd2; b_tx_data = 4'h7; tick();
        b_tx_valid = 0;
        chk8("rst_first_latency", b_net_tx, 8'h00);
        tick();
        chk8("rst_first_seq01", b_net_tx, 8'h67);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
